// File: rtl/ram_arbiter_2p.sv
// Two-master req/ack arbiter and sequencer in front of a single-port RAM with 1-cycle read latency.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module ram_arbiter_2p #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic                  ack0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  ack1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RDCAP} state_t;

  state_t                  state_reg, state_next;
  logic                    port_reg;
  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   din_reg;
  logic [DATA_WIDTH-1:0]   rdata0_reg, rdata1_reg;
  logic                    grant_any;
  logic                    grant_port;
`ifndef ARB_FIXED_PRIO_EN
  logic                    last_gnt_reg;
`endif

  // Winner selection; only meaningful while grant_any is high.
  always_comb begin
    grant_any = req0 | req1;
`ifdef ARB_FIXED_PRIO_EN
    grant_port = ~req0;
`else
    if (req0 && req1) begin
      grant_port = ~last_gnt_reg;
    end else begin
      grant_port = ~req0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ack0       = 1'b0;
    ack1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    ram_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ack0       = ~port_reg;
        ack1       = port_reg;
        ram_we     = we_reg;
        state_next = we_reg ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        state_next = RDCAP;
      end
      RDCAP: begin
        rvalid0    = ~port_reg;
        rvalid1    = port_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch is loaded only on an accept, so RAM address/data hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_reg     <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      din_reg      <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_reg <= 1'b1;
`endif
    end else if (state_reg == IDLE && grant_any) begin
      port_reg     <= grant_port;
      we_reg       <= grant_port ? we1 : we0;
      addr_reg     <= grant_port ? addr1 : addr0;
      din_reg      <= grant_port ? din1 : din0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_reg <= grant_port;
`endif
    end
  end

  // ram_dout is valid during RDWAIT; capturing at its end makes rdata visible with rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else if (state_reg == RDWAIT) begin
      if (port_reg) begin
        rdata1_reg <= ram_dout;
      end else begin
        rdata0_reg <= ram_dout;
      end
    end
  end

  assign ram_addr = addr_reg;
  assign ram_din  = din_reg;
  assign rdata0   = rdata0_reg;
  assign rdata1   = rdata1_reg;
  assign busy     = (state_reg != IDLE);

endmodule
